// File: rtl/pcm_sample_feed.sv
// PCM sample FIFO feeding an I2S output stage: rate-controlled fetch of mono or
// stereo entries, volume scaling, and 24-bit signed outputs updated once per frame.
module pcm_sample_feed #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [15:0]           wr_data,
    input  logic                  cfg_16bit,
    input  logic                  cfg_stereo,
    input  logic [7:0]            cfg_rate,
    input  logic [3:0]            cfg_volume,
    input  logic                  fifo_reset,
    input  logic                  next_sample,
    output logic [23:0]           left_data,
    output logic [23:0]           right_data,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  underrun,
    output logic                  overflow,
    output logic [1:0]            dbg_state_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {IDLE, FETCH_L, FETCH_R, UPDATE} state_t;

    // Handshake: wr_en is a fire-and-forget strobe; a write is taken when the
    // FIFO has room or a pop happens in the same cycle, otherwise overflow pulses.
    logic [15:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic [6:0]            phase_q;
    state_t                state_q;
    logic                  stereo_q;
    logic [15:0]           hold_l_q, hold_r_q;
    logic [23:0]           left_q, right_q;
    logic                  underrun_q, overflow_q;

    logic                  full, pop, push, have_entries;
    logic [15:0]           sample_in, rd_data;
    logic [7:0]            rate_eff, sum;
    logic signed [19:0]    prod_l, prod_r;

    assign full         = (level_q == LVL_FULL);
    assign pop          = (state_q == FETCH_L) || (state_q == FETCH_R);
    assign push         = wr_en && !fifo_reset && (!full || pop);
    assign sample_in    = cfg_16bit ? wr_data : {wr_data[7:0], 8'h00};
    assign rd_data      = mem_q[rd_ptr_q];
    assign rate_eff     = cfg_rate[7] ? 8'd128 : cfg_rate;
    assign sum          = {1'b0, phase_q} + rate_eff;
    assign have_entries = cfg_stereo ? (level_q >= (DEPTH_LOG2+1)'(2)) : (level_q != '0);

    // Signed sample times unsigned gain; the result always fits in 20 bits.
    assign prod_l = 20'($signed(hold_l_q)) * $signed({16'd0, cfg_volume});
    assign prod_r = 20'($signed(hold_r_q)) * $signed({16'd0, cfg_volume});

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || fifo_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            phase_q    <= '0;
            state_q    <= IDLE;
            stereo_q   <= 1'b0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            left_q     <= '0;
            right_q    <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            overflow_q <= wr_en && full && !pop;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push && !pop)      level_q <= level_q + LVL_ONE;
            else if (pop && !push) level_q <= level_q - LVL_ONE;

            case (state_q)
                IDLE: begin
                    if (next_sample) begin
                        phase_q <= sum[6:0];
                        if (sum[7]) begin
                            if (have_entries) begin
                                stereo_q <= cfg_stereo;
                                state_q  <= FETCH_L;
                            end else begin
                                underrun_q <= 1'b1;
                                left_q     <= '0;
                                right_q    <= '0;
                            end
                        end
                    end
                end
                FETCH_L: begin
                    hold_l_q <= rd_data;
                    if (stereo_q) begin
                        state_q <= FETCH_R;
                    end else begin
                        hold_r_q <= rd_data;
                        state_q  <= UPDATE;
                    end
                end
                FETCH_R: begin
                    hold_r_q <= rd_data;
                    state_q  <= UPDATE;
                end
                UPDATE: begin
                    left_q  <= {prod_l, 4'h0};
                    right_q <= {prod_r, 4'h0};
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign left_data   = left_q;
    assign right_data  = right_q;
    assign fifo_full   = full;
    assign fifo_empty  = (level_q == '0);
    assign fifo_level  = level_q;
    assign underrun    = underrun_q;
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;
endmodule
